multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: op in 7, IR[6:0]; zero in 1, ALU zero flag; mem_ready in 1, memory completes the current access.
REQ-003 SHALL have ports: mem_req out 1; MemWrite out 1; AdrSrc out 1, 0 = PC, 1 = ALUOut; IRWrite out 1; PCWrite out 1; RegWrite out 1.
REQ-004 SHALL have ports: ALUSrcA out 2; ALUSrcB out 2; ALUOp out 2, feeds the ALU control decoder; ResultSrc out 2.
REQ-005 SHALL have ports: illegal out 1, sticky trap flag; state out 4, debug; retired out 32, retired-instruction count.

Function
REQ-006 SHALL be a Moore FSM with encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11; codes 12-15 SHALL go to TRAP.
REQ-007 SHALL stay in FETCH while mem_ready=0, and go FETCH->DECODE when mem_ready=1.
REQ-008 SHALL leave DECODE on op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BEQ
- 1101111 -> JAL
- any other value -> TRAP
REQ-009 SHALL leave MEMADR to MEMREAD if op=0000011, else to MEMWRITE.
REQ-010 SHALL stay in MEMREAD while mem_ready=0 and go to MEMWB when mem_ready=1; MEMWRITE SHALL stay while mem_ready=0 and go to FETCH when mem_ready=1.
REQ-011 SHALL go MEMWB->FETCH, EXECR->ALUWB, EXECI->ALUWB, ALUWB->FETCH, BEQ->FETCH and JAL->ALUWB.
REQ-012 SHALL hold TRAP until rst_n goes low, with illegal=1 and every strobe 0.
REQ-013 SHALL drive 0 on every output not listed for the current state.
REQ-014 SHALL drive in FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=mem_ready, PCWrite=mem_ready.
REQ-015 SHALL drive in DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch-target precompute).
REQ-016 SHALL drive in MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-017 SHALL drive in MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00.
REQ-018 SHALL drive in MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, ResultSrc=00.
REQ-019 SHALL drive in MEMWB: ResultSrc=01, RegWrite=1.
REQ-020 SHALL drive in EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
REQ-021 SHALL drive in EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
REQ-022 SHALL drive in ALUWB: ResultSrc=00, RegWrite=1.
REQ-023 SHALL drive in BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero.
REQ-024 SHALL drive in JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
REQ-025 SHALL keep MemWrite, RegWrite, IRWrite and PCWrite as single-cycle strobes, never asserted on two consecutive cycles for the same access except while mem_ready=0 gates them to 0.
REQ-026 SHALL increment retired by 1 on the clock edge of each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ, and SHALL wrap 0xFFFFFFFF->0.
REQ-027 SHALL set illegal on entry to TRAP and never clear it except by reset.
REQ-028 SHALL use the mem_ready value sampled at the edge only; combinational gating per REQ-014 is the only same-cycle use.

Reset
REQ-029 SHALL, while rst_n=0, force state=FETCH, retired=0 and illegal=0 asynchronously, regardless of clk.
REQ-030 SHALL, on rst_n assertion mid-instruction (including inside a MEMREAD/MEMWRITE stall), abandon the instruction without incrementing retired.
REQ-031 SHALL drive outputs per FETCH (REQ-014) during reset; MemWrite and RegWrite SHALL be 0.
REQ-032 SHALL leave reset on the first rising clk after rst_n=1.

Verification
REQ-033 SHALL cover R-type: op=0110011, mem_ready=1 -> states 0,1,6,8,0; ALUOp=10 in EXECR; RegWrite=1 in ALUWB only; retired 0->1.
REQ-034 SHALL cover load with stall: op=0000011, mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles; mem_req=1 and AdrSrc=1 throughout; then MEMWB with ResultSrc=01 and RegWrite=1.
REQ-035 SHALL cover beq: op=1100011 with zero=1 -> PCWrite=1 in BEQ; with zero=0 -> PCWrite=0; ALUOp=01 in both; retired +1 each.
REQ-036 SHALL cover illegal opcode: op=0000000 -> TRAP, illegal=1, all strobes 0 for 10+ cycles; rst_n pulse -> FETCH, illegal=0.
REQ-037 SHALL cover reset mid-store: rst_n low while in MEMWRITE with mem_ready=0 -> immediate FETCH, MemWrite=0, retired unchanged at 0.
REQ-038 SHALL cover counter wrap: retired preloaded to 0xFFFFFFFF by forcing, one R-type -> retired=0x00000000.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multicycle RV32 datapath: per-state datapath selects and
// write strobes, a sticky illegal-opcode trap and a retired-instruction counter.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ResultSrc,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC <= PC+4 when memory answers
    // DECODE   | register read, branch target precompute
    // MEMADR   | effective address for load/store
    // MEMREAD  | load access, held until mem_ready
    // MEMWB    | load data to register file
    // MEMWRITE | store access, held until mem_ready
    // EXECR    | register-register ALU op
    // EXECI    | register-immediate ALU op
    // ALUWB    | ALU result to register file
    // BEQ      | compare, redirect PC on zero
    // JAL      | PC <= target, link computed in ALUWB
    // TRAP     | unsupported opcode, parked until reset
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic [3:0] state_nxt;
    logic       retire;

    always_comb begin
        state_nxt = S_TRAP;
        retire    = 1'b0;
        case (state)
            S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_BEQ:            state_nxt = S_BEQ;
                    OP_JAL:            state_nxt = S_JAL;
                    default:           state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR:   state_nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                state_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
                retire    = mem_ready;
            end
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_BEQ: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_JAL:      state_nxt = S_ALUWB;
            default:    state_nxt = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            retired <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_TRAP)
                illegal <= 1'b1;
            if (retire)
                retired <= retired + 32'd1;
        end
    end

    // Moore outputs; only FETCH IRWrite/PCWrite and BEQ PCWrite look at inputs.
    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        ResultSrc = 2'b00;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:  RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = zero;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through the FSM
// and compares state, control word, illegal and retired against hand-written values.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] retired;

    int n_vec  = 0;
    int n_miss = 0;

    multicycle_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .MemWrite  (MemWrite),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ResultSrc (ResultSrc),
        .illegal   (illegal),
        .state     (state),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // {mem_req,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ALUSrcA,ALUSrcB,ALUOp,ResultSrc}
    wire [13:0] ctl = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                       ALUSrcA, ALUSrcB, ALUOp, ResultSrc};

    localparam logic [13:0] C_FETCH_RDY = 14'b1_0_0_1_1_0_00_10_00_10;
    localparam logic [13:0] C_FETCH_STL = 14'b1_0_0_0_0_0_00_10_00_10;
    localparam logic [13:0] C_DECODE    = 14'b0_0_0_0_0_0_01_01_00_00;
    localparam logic [13:0] C_MEMADR    = 14'b0_0_0_0_0_0_10_01_00_00;
    localparam logic [13:0] C_MEMREAD   = 14'b1_0_1_0_0_0_00_00_00_00;
    localparam logic [13:0] C_MEMWRITE  = 14'b1_1_1_0_0_0_00_00_00_00;
    localparam logic [13:0] C_MEMWB     = 14'b0_0_0_0_0_1_00_00_00_01;
    localparam logic [13:0] C_EXECR     = 14'b0_0_0_0_0_0_10_00_10_00;
    localparam logic [13:0] C_EXECI     = 14'b0_0_0_0_0_0_10_01_10_00;
    localparam logic [13:0] C_ALUWB     = 14'b0_0_0_0_0_1_00_00_00_00;
    localparam logic [13:0] C_BEQ_T     = 14'b0_0_0_0_1_0_10_00_01_00;
    localparam logic [13:0] C_BEQ_NT    = 14'b0_0_0_0_0_0_10_00_01_00;
    localparam logic [13:0] C_JAL       = 14'b0_0_0_0_1_0_01_10_00_00;
    localparam logic [13:0] C_NONE      = 14'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic st_ctl(input string tag, input logic [3:0] s, input logic [13:0] c);
        chk({tag, ".state"}, {28'd0, state}, {28'd0, s});
        chk({tag, ".ctl"}, {18'd0, ctl}, {18'd0, c});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = 7'b0110011;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #12;
        st_ctl("rst", 4'd0, C_FETCH_RDY);
        chk("rst.retired", retired, 32'd0);
        chk("rst.illegal", {31'd0, illegal}, 32'd0);
        tick;
        chk("rst.hold", {28'd0, state}, 32'd0);
        rst_n = 1'b1;

        // R-type: 0,1,6,8,0
        #1;
        st_ctl("r.fetch", 4'd0, C_FETCH_RDY);
        tick; st_ctl("r.decode", 4'd1, C_DECODE);
        tick; st_ctl("r.execr", 4'd6, C_EXECR);
        tick; st_ctl("r.aluwb", 4'd8, C_ALUWB);
        tick; st_ctl("r.done", 4'd0, C_FETCH_RDY);
        chk("r.retired", retired, 32'd1);

        // load with 3-cycle stall in MEMREAD
        op = 7'b0000011;
        tick; st_ctl("ld.decode", 4'd1, C_DECODE);
        tick; st_ctl("ld.memadr", 4'd2, C_MEMADR);
        tick;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            st_ctl($sformatf("ld.memread%0d", i), 4'd3, C_MEMREAD);
            tick;
        end
        st_ctl("ld.memwb", 4'd4, C_MEMWB);
        tick; st_ctl("ld.done", 4'd0, C_FETCH_RDY);
        chk("ld.retired", retired, 32'd2);

        // beq taken, then not taken
        op = 7'b1100011; zero = 1'b1;
        tick; tick; st_ctl("beq.t", 4'd9, C_BEQ_T);
        tick; chk("beq.t.retired", retired, 32'd3);
        zero = 1'b0;
        tick; tick; st_ctl("beq.nt", 4'd9, C_BEQ_NT);
        tick; chk("beq.nt.retired", retired, 32'd4);

        // jal: 1,10,8,0
        op = 7'b1101111;
        tick; tick; st_ctl("jal", 4'd10, C_JAL);
        tick; st_ctl("jal.aluwb", 4'd8, C_ALUWB);
        tick; chk("jal.retired", retired, 32'd5);

        // I-type
        op = 7'b0010011;
        tick; tick; st_ctl("execi", 4'd7, C_EXECI);
        tick; st_ctl("execi.aluwb", 4'd8, C_ALUWB);
        tick; chk("execi.retired", retired, 32'd6);

        // store completing without stall
        op = 7'b0100011;
        tick; tick; st_ctl("st.memadr", 4'd2, C_MEMADR);
        tick; st_ctl("st.memwrite", 4'd5, C_MEMWRITE);
        tick; st_ctl("st.done", 4'd0, C_FETCH_RDY);
        chk("st.retired", retired, 32'd7);

        // fetch stall
        mem_ready = 1'b0;
        #1; st_ctl("fetch.stall", 4'd0, C_FETCH_STL);
        tick; st_ctl("fetch.stall2", 4'd0, C_FETCH_STL);

        // reset mid-store stall
        rst_n = 1'b0; #2; rst_n = 1'b1;
        chk("pulse.retired", retired, 32'd0);
        mem_ready = 1'b1;
        tick; tick; tick; st_ctl("st2.memwrite", 4'd5, C_MEMWRITE);
        mem_ready = 1'b0;
        tick; st_ctl("st2.stall", 4'd5, C_MEMWRITE);
        #2; rst_n = 1'b0; #1;
        st_ctl("st2.rst", 4'd0, C_FETCH_STL);
        chk("st2.rst.retired", retired, 32'd0);
        tick;
        chk("st2.rst.hold", {28'd0, state}, 32'd0);
        chk("st2.rst.retired2", retired, 32'd0);
        rst_n = 1'b1;

        // illegal opcode
        op = 7'b0000000; mem_ready = 1'b1;
        tick; st_ctl("ill.decode", 4'd1, C_DECODE);
        chk("ill.pre", {31'd0, illegal}, 32'd0);
        tick;
        for (int i = 0; i < 12; i++) begin
            op        = (i % 2 == 0) ? 7'b0110011 : 7'b0000011;
            mem_ready = i[0];
            zero      = i[1];
            #1;
            st_ctl($sformatf("ill.trap%0d", i), 4'd11, C_NONE);
            chk($sformatf("ill.flag%0d", i), {31'd0, illegal}, 32'd1);
            tick;
        end
        rst_n = 1'b0; #1;
        chk("ill.rst.state", {28'd0, state}, 32'd0);
        chk("ill.rst.flag", {31'd0, illegal}, 32'd0);
        tick;
        rst_n = 1'b1;

        // retired wrap
        mem_ready = 1'b0; op = 7'b0110011;
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        #1;
        chk("wrap.preload", retired, 32'hFFFF_FFFF);
        mem_ready = 1'b1;
        tick; tick; tick;
        chk("wrap.before", retired, 32'hFFFF_FFFF);
        tick;
        st_ctl("wrap.fetch", 4'd0, C_FETCH_RDY);
        chk("wrap.retired", retired, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
